simon_tone_sequencer: RTL and testbench

Stores the Simon Says colour sequence and plays it back as timed note/gap bursts. Drives the `sound_select`/`play` inputs of `sound_controller`, which sits directly downstream. Game control appends one colour per round, then pulses `start`. The block reports `busy` during playback and pulses `done` when playback ends.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_tone_sequencer_if.sv | 39 +++
 rtl/simon_seq_mem.sv | 35 +++
 rtl/simon_tone_sequencer.sv | 138 +++++++++++++
 tb/tb_simon_tone_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// simon_pkg
// Types shared by the Simon tone sequencer, the sound controller and the
// game FSM.
//   color_t        : the four pad colours, encoded as the sound index
//   seq_state_t    : playback FSM states of the tone sequencer
//   color_to_sound : maps a colour onto the 4-bit sound_select code
package simon_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  // Colour sounds occupy the low four slots of the sound table.
  function automatic logic [3:0] color_to_sound(input color_t color);
    return {2'b00, color};
  endfunction

endpackage

// File: rtl/simon_tone_sequencer_if.sv
// simon_tone_sequencer_if
// Bundles the game-control and sound-controller side signals of the tone
// sequencer.
//   master : game control (drives clear/append/start, observes status and
//            the sound outputs)
//   slave  : the tone sequencer itself
// Signals:
//   clear, append_valid, append_color, append_ready, start : control side
//   busy, done, seq_len, step_idx                          : status
//   sound_select, play                                     : to sound_controller
interface simon_tone_sequencer_if #(parameter int MAX_LEN = 32);
  import simon_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic             clear;
  logic             append_valid;
  color_t           append_color;
  logic             append_ready;
  logic             start;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] seq_len;
  logic [IDX_W-1:0] step_idx;
  logic [3:0]       sound_select;
  logic             play;

  modport master (
    output clear, append_valid, append_color, start,
    input  append_ready, busy, done, seq_len, step_idx, sound_select, play
  );

  modport slave (
    input  clear, append_valid, append_color, start,
    output append_ready, busy, done, seq_len, step_idx, sound_select, play
  );

endinterface

// File: rtl/simon_seq_mem.sv
// simon_seq_mem
// MAX_LEN x 2-bit colour store for the Simon sequence. One synchronous write
// port, one combinational read port. The array has no reset; entries at or
// above seq_len are never read for playback.
//   clk      : system clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_color : colour to store
//   rd_addr  : read index
//   rd_color : colour stored at rd_addr
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 32,
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  color_t           wr_color,
  input  logic [IDX_W-1:0] rd_addr,
  output color_t           rd_color
);

  color_t mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_color;
    end
  end

  assign rd_color = mem[rd_addr];

endmodule

// File: rtl/simon_tone_sequencer.sv
// simon_tone_sequencer
// Stores the Simon colour sequence and plays it back as NOTE_CYCLES of tone
// followed by GAP_CYCLES of silence per step.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of simon_tone_sequencer_if (control, status, and the
//           sound_select/play pair feeding sound_controller)
module simon_tone_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  simon_tone_sequencer_if.slave   bus
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  seq_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [LEN_W-1:0] seq_len;
  logic [IDX_W-1:0] step_idx;
  logic             play;
  logic             done;
  logic [3:0]       sound_select;

  logic             idle;
  logic             append_fire;
  logic [LEN_W-1:0] next_count;
  logic [IDX_W-1:0] rd_addr;
  color_t           rd_color;
  color_t           first_color;

  assign idle             = (state == IDLE);
  assign bus.append_ready = idle && (seq_len < LEN_W'(MAX_LEN));
  assign append_fire      = bus.append_valid && bus.append_ready && !bus.clear;
  assign next_count       = LEN_W'(step_idx) + LEN_W'(1);

  // The read port looks one step ahead so the colour of the next note is
  // ready when the registered sound_select is loaded: step 0 from IDLE,
  // step_idx+1 from GAP.
  assign rd_addr = idle ? '0 : step_idx + IDX_W'(1);

  // On an empty sequence the first step is the one being appended this very
  // cycle, which is not in the array yet, so bypass it.
  assign first_color = (seq_len == '0) ? bus.append_color : rd_color;

  simon_seq_mem #(.MAX_LEN(MAX_LEN)) u_mem (
    .clk      (clk),
    .wr_en    (append_fire),
    .wr_addr  (seq_len[IDX_W-1:0]),
    .wr_color (bus.append_color),
    .rd_addr  (rd_addr),
    .rd_color (rd_color)
  );

  // Playback FSM with registered outputs. clear wins over append and start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      seq_len      <= '0;
      step_idx     <= '0;
      play         <= 1'b0;
      done         <= 1'b0;
      sound_select <= 4'd0;
    end else if (bus.clear) begin
      state        <= IDLE;
      timer        <= '0;
      seq_len      <= '0;
      step_idx     <= '0;
      play         <= 1'b0;
      done         <= 1'b0;
      sound_select <= 4'd0;
    end else begin
      done <= 1'b0;
      if (append_fire) begin
        seq_len <= seq_len + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if ((seq_len != '0) || append_fire) begin
              state        <= NOTE;
              step_idx     <= '0;
              timer        <= TMR_W'(NOTE_CYCLES - 1);
              play         <= 1'b1;
              sound_select <= color_to_sound(first_color);
            end else begin
              done <= 1'b1;
            end
          end
        end
        NOTE: begin
          if (timer == '0) begin
            state        <= GAP;
            timer        <= TMR_W'(GAP_CYCLES - 1);
            play         <= 1'b0;
            sound_select <= 4'd0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        GAP: begin
          if (timer == '0) begin
            if (next_count < seq_len) begin
              state        <= NOTE;
              step_idx     <= step_idx + IDX_W'(1);
              timer        <= TMR_W'(NOTE_CYCLES - 1);
              play         <= 1'b1;
              sound_select <= color_to_sound(rd_color);
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = !idle;
  assign bus.done         = done;
  assign bus.seq_len      = seq_len;
  assign bus.step_idx     = step_idx;
  assign bus.play         = play;
  assign bus.sound_select = sound_select;

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// tb_simon_tone_sequencer
// Directed self-checking bench for simon_tone_sequencer with MAX_LEN=4,
// NOTE_CYCLES=4, GAP_CYCLES=2. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
module tb_simon_tone_sequencer;
  import simon_pkg::*;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  simon_tone_sequencer_if #(.MAX_LEN(4)) bus ();

  simon_tone_sequencer #(
    .MAX_LEN     (4),
    .NOTE_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected normal end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic do_append(input color_t c);
    bus.append_valid = 1'b1;
    bus.append_color = c;
    tick();
    bus.append_valid = 1'b0;
  endtask

  // Red then blue, played back and checked cycle by cycle. Expects an empty
  // sequence on entry.
  task automatic run_red_blue(input string tag);
    logic       exp_play;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_sel;
    do_append(RED);
    do_append(BLUE);
    compared++;
    if (bus.seq_len !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL %s_seq_len: got %0d expected 2", tag, bus.seq_len);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      exp_play = (i <= 4) || (i >= 7 && i <= 10);
      exp_sel  = (i <= 4) ? 4'd1 : ((i >= 7 && i <= 10) ? 4'd3 : 4'd0);
      exp_busy = (i <= 12);
      exp_done = (i == 13);
      compared++;
      if (bus.play !== exp_play) begin
        mismatched++;
        $display("[TB] FAIL %s_play c%0d: got %0b expected %0b", tag, i, bus.play, exp_play);
      end
      compared++;
      if (bus.sound_select !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL %s_sel c%0d: got %0h expected %0h", tag, i, bus.sound_select, exp_sel);
      end
      compared++;
      if (bus.busy !== exp_busy) begin
        mismatched++;
        $display("[TB] FAIL %s_busy c%0d: got %0b expected %0b", tag, i, bus.busy, exp_busy);
      end
      compared++;
      if (bus.done !== exp_done) begin
        mismatched++;
        $display("[TB] FAIL %s_done c%0d: got %0b expected %0b", tag, i, bus.done, exp_done);
      end
      if (i == 1 || i == 7) begin
        compared++;
        if (bus.step_idx !== ((i == 1) ? 2'd0 : 2'd1)) begin
          mismatched++;
          $display("[TB] FAIL %s_step c%0d: got %0d expected %0d", tag, i, bus.step_idx, (i == 1) ? 0 : 1);
        end
      end
      if (i < 13) tick();
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.clear        = 1'b0;
    bus.append_valid = 1'b0;
    bus.append_color = GREEN;
    bus.start        = 1'b0;
    tick();
    tick();
    compared++;
    if ({bus.busy, bus.done, bus.play} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.play});
    end
    compared++;
    if (bus.sound_select !== 4'd0 || bus.seq_len !== 3'd0 || bus.step_idx !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got sel=%0h len=%0d step=%0d expected 0/0/0",
               bus.sound_select, bus.seq_len, bus.step_idx);
    end
    compared++;
    if (bus.append_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %0b expected 1", bus.append_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_playback();
    do_clear();
    run_red_blue("s1");
  endtask

  task automatic test_full_sequence();
    color_t cols [4];
    cols = '{BLUE, GREEN, YELLOW, RED};
    do_clear();
    for (int j = 0; j < 4; j++) do_append(cols[j]);
    compared++;
    if (bus.seq_len !== 3'd4 || bus.append_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_len: got len=%0d ready=%0b expected 4/0", bus.seq_len, bus.append_ready);
    end
    do_append(GREEN);
    compared++;
    if (bus.seq_len !== 3'd4) begin
      mismatched++;
      $display("[TB] FAIL full_ignore: got %0d expected 4", bus.seq_len);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if ((i - 1) % 6 == 0 && i < 25) begin
        compared++;
        if (bus.step_idx !== 2'((i - 1) / 6) || bus.play !== 1'b1 ||
            bus.sound_select !== {2'b00, cols[(i - 1) / 6]}) begin
          mismatched++;
          $display("[TB] FAIL full_step c%0d: got step=%0d play=%0b sel=%0h expected %0d/1/%0h",
                   i, bus.step_idx, bus.play, bus.sound_select, (i - 1) / 6, cols[(i - 1) / 6]);
        end
      end
      if (i == 25) begin
        compared++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.step_idx !== 2'd3) begin
          mismatched++;
          $display("[TB] FAIL full_end: got done=%0b busy=%0b step=%0d expected 1/0/3",
                   bus.done, bus.busy, bus.step_idx);
        end
      end
      if (i < 25) tick();
    end
  endtask

  task automatic test_empty_start();
    do_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    compared++;
    if ({bus.busy, bus.play, bus.done} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL empty_start: got busy,play,done=%b expected 001", {bus.busy, bus.play, bus.done});
    end
    tick();
    compared++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL empty_after: got busy,done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_clear_mid_note();
    do_clear();
    do_append(GREEN);
    do_append(RED);
    do_append(YELLOW);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    compared++;
    if (bus.step_idx !== 2'd1 || bus.play !== 1'b1 || bus.sound_select !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL clear_pre: got step=%0d play=%0b sel=%0h expected 1/1/1",
               bus.step_idx, bus.play, bus.sound_select);
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    compared++;
    if ({bus.play, bus.busy, bus.done} !== 3'b000 || bus.seq_len !== 3'd0 ||
        bus.step_idx !== 2'd0 || bus.sound_select !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL clear_post: got play,busy,done=%b len=%0d step=%0d sel=%0h expected 000/0/0/0",
               {bus.play, bus.busy, bus.done}, bus.seq_len, bus.step_idx, bus.sound_select);
    end
    tick();
    compared++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL clear_nodone: got busy,done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_append(RED);
    do_append(BLUE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    compared++;
    if (bus.play !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL areset_pre: got play=%0b expected 1", bus.play);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.play, bus.busy} !== 2'b00 || bus.sound_select !== 4'd0 || bus.seq_len !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL areset_now: got play,busy=%b sel=%0h len=%0d expected 00/0/0",
               {bus.play, bus.busy}, bus.sound_select, bus.seq_len);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_red_blue("s5");
  endtask

  task automatic test_back_to_back();
    logic exp_play;
    logic exp_busy;
    logic exp_done;
    do_clear();
    bus.append_valid = 1'b1;
    bus.append_color = GREEN;
    bus.start        = 1'b1;
    tick();
    bus.append_valid = 1'b0;
    bus.start        = 1'b0;
    compared++;
    if (bus.seq_len !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_len: got %0d expected 1", bus.seq_len);
    end
    for (int i = 1; i <= 8; i++) begin
      exp_play = (i <= 4);
      exp_busy = (i <= 6);
      exp_done = (i == 7);
      compared++;
      if (bus.play !== exp_play || bus.busy !== exp_busy || bus.done !== exp_done ||
          bus.sound_select !== 4'd0) begin
        mismatched++;
        $display("[TB] FAIL b2b c%0d: got play,busy,done=%b sel=%0h expected %b/0",
                 i, {bus.play, bus.busy, bus.done}, bus.sound_select, {exp_play, exp_busy, exp_done});
      end
      if (i == 2 || i == 5) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    $display("[TB] starting simon_tone_sequencer bench");
    test_reset();
    test_basic_playback();
    test_full_sequence();
    test_empty_start();
    test_clear_mid_note();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
